uart_tx_cfg: RTL and testbench

- Parametrised UART transmitter, successor to the fixed 8N1 tx block.
- Configurable data width and oversampling. Parity (none/even/odd) and 1 or 2 stop bits are selected per frame at runtime.
- Adds a busy flag and a one-deep holding register, so frames can be sent back to back with no idle gap.
- Sits between the ALU/interface logic and the pin; driven by the shared baudRateGenerator tick.

---
 rtl/uart_tx_cfg.sv | 207 ++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with runtime parity / stop-bit
// selection, a busy flag and a one-deep holding register so that frames can
// be sent back to back with no idle gap between them.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line idle high, waiting for the holding register to fill
// START  | driving the start bit (0) for OVERSAMPLE ticks
// DATA   | shifting out NB_DATA bits LSB first, OVERSAMPLE ticks each
// PARITY | driving the even/odd parity bit for OVERSAMPLE ticks
// STOP   | driving 1 for SB_TICK or 2*SB_TICK ticks, then done pulse
module uart_tx_cfg #(
    parameter int NB_DATA    = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICK    = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    input  logic [1:0]         i_parity_mode,
    input  logic               i_stop2,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_full,
    output logic               o_tx_done_tick
);

    // The tick counter must reach both the bit length and the two-stop length.
    localparam int S_MAX = (OVERSAMPLE > 2*SB_TICK) ? OVERSAMPLE : 2*SB_TICK;
    localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int N_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [S_W-1:0] S_BIT_LAST   = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP1_LAST = S_W'(SB_TICK - 1);
    localparam logic [S_W-1:0] S_STOP2_LAST = S_W'(2*SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST       = N_W'(NB_DATA - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t             r_state;
    logic [S_W-1:0]     r_s;
    logic [N_W-1:0]     r_n;
    logic [NB_DATA-1:0] r_shift;
    logic               r_par_en;
    logic               r_par_bit;
    logic               r_stop2;
    logic               r_tx;
    logic               r_done;

    logic [NB_DATA-1:0] r_hold_data;
    logic [1:0]         r_hold_mode;
    logic               r_hold_stop2;
    logic               r_full;

    logic w_bit_last;
    logic w_stop_last;
    logic w_drain;
    logic w_accept;
    logic w_hold_par_en;
    logic w_hold_par_bit;

    assign w_bit_last  = (r_s == S_BIT_LAST);
    assign w_stop_last = (r_s == (r_stop2 ? S_STOP2_LAST : S_STOP1_LAST));

    // The holding register empties into the shifter either from IDLE or on the
    // last stop tick, which is what lets consecutive frames abut.
    assign w_drain = r_full &&
                     ((r_state == ST_IDLE) ||
                      ((r_state == ST_STOP) && i_tick && w_stop_last));

    // A request landing in the same clock as a drain sees the register empty.
    assign w_accept = i_tx_start && (!r_full || w_drain);

    // Parity is derived from the held copy so later changes on i_data are moot.
    assign w_hold_par_en  = r_hold_mode[0] ^ r_hold_mode[1];
    assign w_hold_par_bit = (^r_hold_data) ^ r_hold_mode[1];

    // Holding register: capture on accepted request, release on drain.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hold_data  <= '0;
            r_hold_mode  <= 2'b00;
            r_hold_stop2 <= 1'b0;
            r_full       <= 1'b0;
        end else if (w_accept) begin
            r_hold_data  <= i_data;
            r_hold_mode  <= i_parity_mode;
            r_hold_stop2 <= i_stop2;
            r_full       <= 1'b1;
        end else if (w_drain) begin
            r_full       <= 1'b0;
        end
    end

    // Frame sequencer with registered line and done outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_s       <= '0;
            r_n       <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_drain) begin
                r_state   <= ST_START;
                r_s       <= '0;
                r_n       <= '0;
                r_shift   <= r_hold_data;
                r_par_en  <= w_hold_par_en;
                r_par_bit <= w_hold_par_bit;
                r_stop2   <= r_hold_stop2;
                r_tx      <= 1'b0;
                if (r_state == ST_STOP) begin
                    r_done <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_tx <= 1'b1;
                        r_s  <= '0;
                    end
                    ST_START: begin
                        if (i_tick) begin
                            if (w_bit_last) begin
                                r_s     <= '0;
                                r_n     <= '0;
                                r_state <= ST_DATA;
                                r_tx    <= r_shift[0];
                            end else begin
                                r_s <= r_s + S_W'(1);
                            end
                        end
                    end
                    ST_DATA: begin
                        if (i_tick) begin
                            if (w_bit_last) begin
                                r_s     <= '0;
                                r_shift <= r_shift >> 1;
                                if (r_n == N_LAST) begin
                                    if (r_par_en) begin
                                        r_state <= ST_PARITY;
                                        r_tx    <= r_par_bit;
                                    end else begin
                                        r_state <= ST_STOP;
                                        r_tx    <= 1'b1;
                                    end
                                end else begin
                                    r_n  <= r_n + N_W'(1);
                                    r_tx <= r_shift[1];
                                end
                            end else begin
                                r_s <= r_s + S_W'(1);
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (i_tick) begin
                            if (w_bit_last) begin
                                r_s     <= '0;
                                r_state <= ST_STOP;
                                r_tx    <= 1'b1;
                            end else begin
                                r_s <= r_s + S_W'(1);
                            end
                        end
                    end
                    ST_STOP: begin
                        r_tx <= 1'b1;
                        if (i_tick) begin
                            if (w_stop_last) begin
                                r_s     <= '0;
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_s <= r_s + S_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                        r_s     <= '0;
                    end
                endcase
            end
        end
    end

    assign o_tx           = r_tx;
    assign o_full         = r_full;
    assign o_tx_done_tick = r_done;
    assign o_busy         = (r_state != ST_IDLE) | r_full;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: two instances (8-bit/16x and 7-bit/8x) share the
// stimulus; a monitor decodes the selected line against queued frames.
module tb_uart_tx_cfg;

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        logic       stop2;
    } frm_t;

    logic       clk = 0;
    logic       rst = 1;
    logic       tick = 0;
    logic       start = 0;
    logic [7:0] data = 0;
    logic [1:0] mode = 0;
    logic       stop2 = 0;
    logic       sel = 0;
    int         tick_div = 4;

    logic tx8, busy8, full8, done8;
    logic tx7, busy7, full7, done7;

    frm_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_count = 0;
    bit   in_frame = 0;

    uart_tx_cfg #(.NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(16)) dut (
        .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start),
        .i_data(data), .i_parity_mode(mode), .i_stop2(stop2),
        .o_tx(tx8), .o_busy(busy8), .o_full(full8), .o_tx_done_tick(done8)
    );

    uart_tx_cfg #(.NB_DATA(7), .OVERSAMPLE(8), .SB_TICK(8)) dut7 (
        .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start),
        .i_data(data[6:0]), .i_parity_mode(mode), .i_stop2(stop2),
        .o_tx(tx7), .o_busy(busy7), .o_full(full7), .o_tx_done_tick(done7)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Tick generator: one-clock pulse every tick_div clocks.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            cnt++;
            if (cnt >= tick_div) begin
                cnt = 0;
                tick = 1;
            end else begin
                tick = 0;
            end
        end
    end

    // Monitor: receiver model checking every tick of each frame.
    logic       prev_line = 1;
    int         ticks, tot_ticks, pre, os, sb, nb;
    logic       exp_bits[0:11];
    logic [7:0] rx;
    frm_t       cur;
    always @(posedge clk) begin
        logic line, dn, e;
        logic [7:0] d;
        int ones;
        #1;
        line = sel ? tx7 : tx8;
        dn   = sel ? done7 : done8;
        if (rst) begin
            in_frame  = 0;
            prev_line = 1;
            chk("done_in_reset", dn, 0);
        end else begin
            if (in_frame) begin
                if (tick) begin
                    ticks++;
                    if (ticks < tot_ticks) begin
                        e = (ticks < pre*os) ? exp_bits[ticks/os] : 1'b1;
                        chk("line_bit", line, e);
                        if ((ticks % os) == os/2 && ticks/os >= 1 && ticks/os <= nb)
                            rx[ticks/os - 1] = line;
                    end
                end
                if (dn) begin
                    done_count++;
                    chk("done_time", ticks, tot_ticks);
                    d = cur.data & 8'((1 << nb) - 1);
                    chk("rx_data", rx, d);
                    in_frame = 0;
                end else if (ticks >= tot_ticks) begin
                    chk("done_missing", 0, 1);
                    in_frame = 0;
                end
            end else if (dn) begin
                chk("spurious_done", dn, 0);
            end
            if (!in_frame && prev_line == 1'b1 && line == 1'b0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    cur = sb_q.pop_front();
                    nb  = sel ? 7 : 8;
                    os  = sel ? 8 : 16;
                    sb  = sel ? 8 : 16;
                    d   = cur.data & 8'((1 << nb) - 1);
                    exp_bits[0] = 1'b0;
                    for (int i = 0; i < nb; i++) exp_bits[1+i] = d[i];
                    pre = 1 + nb;
                    if (cur.mode == 2'b01 || cur.mode == 2'b10) begin
                        ones = $countones(d);
                        exp_bits[pre] = (cur.mode == 2'b01) ? logic'(ones % 2) : logic'(1 - ones % 2);
                        pre++;
                    end
                    tot_ticks = pre*os + sb*(cur.stop2 ? 2 : 1);
                    ticks = 0;
                    rx = 0;
                    in_frame = 1;
                end
            end
            prev_line = line;
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] m, input logic s2, input bit expect_accept);
        frm_t f;
        @(negedge clk);
        data = d; mode = m; stop2 = s2; start = 1;
        if (expect_accept) begin
            f.data = d; f.mode = m; f.stop2 = s2;
            sb_q.push_back(f);
        end
        @(negedge clk);
        start = 0;
        data = 8'($urandom); mode = 2'($urandom); stop2 = 1'($urandom);
    endtask

    task automatic wait_done(input int maxc);
        bit ok;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk);
            #1;
            if (sel ? done7 : done8) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_outstanding(input int lim);
        bit ok;
        ok = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (sb_q.size() + int'(in_frame) <= lim) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    task automatic random_frames(input int n);
        for (int k = 0; k < n; k++) begin
            wait_outstanding(1);
            repeat ($urandom_range(2, 40)) @(negedge clk);
            tick_div = $urandom_range(1, 4);
            send(8'($urandom), 2'($urandom), 1'($urandom), 1);
        end
        wait_outstanding(0);
        tick_div = 4;
    endtask

    initial begin
        int dc0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_full", full8, 0);
        chk("rst_done", done8, 0);
        rst = 0;
        repeat (5) @(negedge clk);

        // Test 1: 8N1, latency and frame length
        dc0 = done_count;
        send(8'hE5, 2'b00, 1'b0, 1);
        chk("t1_full_after_req", full8, 1);
        chk("t1_tx_one_clock", tx8, 1);
        @(posedge clk);
        #1;
        chk("t1_tx_two_clocks", tx8, 0);
        wait_done(4000);
        @(posedge clk);
        #1;
        chk("t1_busy_after_done", busy8, 0);
        chk("t1_done_count", done_count - dc0, 1);

        // Test 2: even then odd parity
        send(8'hE5, 2'b01, 1'b0, 1);
        wait_done(4000);
        send(8'hE5, 2'b10, 1'b0, 1);
        wait_done(4000);

        // Test 3: two stop bits
        send(8'h00, 2'b00, 1'b1, 1);
        wait_done(4000);
        @(posedge clk);
        #1;
        chk("t3_busy_after_done", busy8, 0);

        // Test 4: back to back, third request dropped
        repeat (5) @(negedge clk);
        dc0 = done_count;
        send(8'h5A, 2'b00, 1'b0, 1);
        repeat (12) @(negedge clk);
        send(8'hC3, 2'b00, 1'b0, 1);
        chk("t4_full_second", full8, 1);
        send(8'hFF, 2'b00, 1'b0, 0);
        chk("t4_full_third", full8, 1);
        wait_done(4000);
        chk("t4_no_gap", tx8, 0);
        chk("t4_drained", full8, 0);
        wait_done(4000);
        repeat (3) @(negedge clk);
        chk("t4_done_count", done_count - dc0, 2);

        // Test 5: reset during data bit 3
        dc0 = done_count;
        send(8'hA5, 2'b00, 1'b0, 1);
        repeat (290) @(negedge clk);
        rst = 1;
        sb_q.delete();
        #1;
        chk("t5_tx", tx8, 1);
        chk("t5_busy", busy8, 0);
        chk("t5_full", full8, 0);
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (5) @(negedge clk);
        chk("t5_no_done", done_count - dc0, 0);
        send(8'h3C, 2'b00, 1'b0, 1);
        wait_done(4000);

        // Randomized frames on the 8-bit instance
        random_frames(10);

        // Test 6: 7-bit, 8x instance
        @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        chk("t6_rst_tx", tx7, 1);
        chk("t6_rst_busy", busy7, 0);
        sel = 1;
        rst = 0;
        repeat (3) @(negedge clk);
        send(8'h55, 2'b01, 1'b0, 1);
        wait_done(4000);
        random_frames(6);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
